cdc_mem_bridge: RTL
===================

Name: cdc_mem_bridge

Overview:
- Debug/boot responder on the USB_CDC byte stream. The host is the initiator; this block decodes framed host commands and issues 32-bit word reads/writes on a simple memory bus.
- Returns response bytes to the host over the same stream.
- Sits between the USB_CDC core and the data memory/IO bus, in parallel with fifo_if. The host can load or inspect memory while the core is held.

Parameters:
- TIMEOUT, 1024, max cycles mem_req_o may stay high without mem_ack_i before the access is abandoned.
- TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- rx_data_i  in  8  byte from host (USB_CDC out_data)
- rx_valid_i  in  1  rx byte valid
- rx_ready_o  out  1  bridge can accept rx byte
- tx_data_o  out  8  byte to host (USB_CDC in_data)
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  USB_CDC accepts tx byte
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  1=write, 0=read; valid while mem_req_o
- mem_addr_o  out  32  word-aligned byte address
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data; valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion strobe

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: rx_ready_o=0, tx_valid_o=0, tx_data_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. State=IDLE.
- rx_ready_o goes to 1 the cycle after reset deasserts.
- A transfer occurs on any cycle where valid&ready.
- Commands; multi-byte fields are little-endian:
  - 0x50 'P' ping -> respond 0x4B.
  - 0x57 'W' + 4 addr bytes + 4 data bytes -> write, then respond 0x4B 'K'.
  - 0x52 'R' + 4 addr bytes -> read, then respond 4 data bytes, LSB first.
  - Any other command byte -> respond 0x3F '?'.
- States:
  - IDLE: rx_ready_o=1. On accept: 'P' -> RESP(0x4B); 'W'/'R' -> ADDR (cnt=0, latch we); other -> RESP(0x3F).
  - ADDR: rx_ready_o=1. Each accepted byte is shifted into addr[8*cnt+:8]. After the 4th byte:
    - addr[1:0]!=0 -> RESP(0x45 'E') with no memory access.
    - else 'W' -> DATA (cnt=0).
    - else 'R' -> MEM.
  - DATA: rx_ready_o=1. Collects 4 bytes into wdata, then -> MEM.
  - MEM: rx_ready_o=0, mem_req_o=1 with addr/we/wdata held stable.
    - Timeout counter increments each cycle with req high and no ack.
    - mem_ack_i -> drop req the next cycle. Write -> RESP(0x4B). Read -> latch rdata, RESP(4 bytes).
    - Counter reaching TIMEOUT with no ack -> drop req, RESP(0x45).
    - Ack in the same cycle as timeout: ack wins.
    - Ack arriving outside MEM is ignored.
  - RESP: rx_ready_o=0, tx_valid_o=1. tx_data_o holds stable until tx_ready_i. The byte index advances on accept. After the last byte -> IDLE.
    - tx_valid_o is asserted the cycle after entering RESP.
- Latency: the first response byte is presented 1 cycle after the final command byte is accepted (ping/error), or 1 cycle after mem_ack_i.
- Backpressure: rx bytes are never dropped. The next command is not accepted until the response has fully drained. There is no inter-byte timeout; a partial command waits indefinitely.
- rst_i mid-operation: immediate abort. mem_req_o and tx_valid_o drop on the next edge, and the partial command is discarded.
- Counters: cnt is 2 bits and wraps naturally at 4 bytes. The timeout counter clears on entry to MEM.

Test Plan:
- Reset then ping: rx 0x50 -> tx exactly one byte 0x4B. rx_ready_o low until tx accepted, then high.
- Write: rx 57 00 01 00 00 EF BE AD DE -> one mem_req with we=1, addr=0x00000100, wdata=0xDEADBEEF; ack after 3 cycles -> tx 0x4B. Req high for exactly 4 cycles.
- Read with tx backpressure: rx 52 04 01 00 00, ack rdata=0x12345678 -> tx 78 56 34 12. With tx_ready_i toggled 0/1, each byte is held stable while unaccepted.
- Errors:
  - rx 52 02 00 00 00 -> tx 0x45 with no mem_req.
  - rx 0x33 -> tx 0x3F.
  - Read with no ack and TIMEOUT=8 -> req drops after 8 cycles, tx 0x45.
- Simultaneous/abort: ack in the timeout cycle -> normal response. rst_i asserted during DATA after 2 bytes -> all outputs at reset values; a following ping answers 0x4B.

Source files
------------

// File: rtl/cdc_mem_bridge.sv
// -----------------------------------------------------------------------------
// cdc_mem_bridge
//
// Debug/boot responder on the USB_CDC byte stream. The host sends framed
// commands; the bridge turns them into single 32-bit word accesses on a simple
// req/ack memory bus and returns response bytes over the same stream.
//
// Command set (multi-byte fields little-endian):
//   'P' 0x50                      -> 0x4B
//   'W' 0x57 + addr[4] + data[4]  -> write, then 0x4B
//   'R' 0x52 + addr[4]            -> read, then 4 data bytes LSB first
//   anything else                 -> 0x3F
//   misaligned address / bus timeout -> 0x45
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_data_i/valid_i     host -> bridge byte stream, rx_ready_o backpressure
//   tx_data_o/valid_o     bridge -> host byte stream, tx_ready_i backpressure
//   mem_req_o/we_o        access request, held until ack or timeout
//   mem_addr_o/wdata_o    word-aligned address and write data (stable while req)
//   mem_rdata_i/ack_i     read data qualified by the one-cycle ack strobe
// -----------------------------------------------------------------------------
module cdc_mem_bridge #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_UNK   = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // Response bytes still to send; the byte on the wire is always resp_q[7:0]
    // so tx_data_o cannot move until the host takes it.
    logic [31:0]   resp_q, resp_d;
    // Number of bytes that follow the one currently presented.
    logic [1:0]    resp_left_q, resp_left_d;
    logic          rx_ready_q, rx_ready_d;
    logic          tx_valid_q, tx_valid_d;
    logic          mem_req_q, mem_req_d;

    logic          rx_fire;
    logic          tx_fire;

    assign rx_fire = rx_valid_i & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready_i;

    assign rx_ready_o  = rx_ready_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = resp_q[7:0];
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_d       = tmo_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == CMD_PING) begin
                        resp_d      = {24'h0, RSP_OK};
                        resp_left_d = 2'd0;
                        state_d     = S_RESP;
                    end else if ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)) begin
                        we_d    = (rx_data_i == CMD_WRITE);
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        resp_d      = {24'h0, RSP_UNK};
                        resp_left_d = 2'd0;
                        state_d     = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (rx_fire) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Alignment is judged on the complete address; a
                        // misaligned write is refused before its data bytes.
                        if (addr_d[1:0] != 2'b00) begin
                            resp_d      = {24'h0, RSP_ERR};
                            resp_left_d = 2'd0;
                            state_d     = S_RESP;
                        end else if (we_q) begin
                            state_d = S_DATA;
                        end else begin
                            tmo_d   = '0;
                            state_d = S_MEM;
                        end
                    end
                end
            end

            S_DATA: begin
                if (rx_fire) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = S_MEM;
                    end
                end
            end

            S_MEM: begin
                // Ack is tested first so that an ack landing in the final
                // timeout cycle still completes the access normally.
                if (mem_ack_i) begin
                    if (we_q) begin
                        resp_d      = {24'h0, RSP_OK};
                        resp_left_d = 2'd0;
                    end else begin
                        resp_d      = mem_rdata_i;
                        resp_left_d = 2'd3;
                    end
                    state_d = S_RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    resp_d      = {24'h0, RSP_ERR};
                    resp_left_d = 2'd0;
                    state_d     = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_RESP: begin
                if (tx_fire) begin
                    if (resp_left_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_d      = {8'h00, resp_q[31:8]};
                        resp_left_d = resp_left_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state, so they
        // change exactly on the edge that moves the FSM.
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
        tx_valid_d = (state_d == S_RESP);
        mem_req_d  = (state_d == S_MEM);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            tmo_q       <= '0;
            resp_q      <= 32'h0;
            resp_left_q <= 2'd0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            mem_req_q   <= mem_req_d;
        end
    end

endmodule
